adder_tree_accum_ctrl: RTL and testbench

//  Sequencer for the 8-lane dual (pos/neg) adder tree in the ternary CiM MAC path.

---
 rtl/adder_tree_accum_ctrl.sv | 155 +++++++++++++++
 tb/tb_adder_tree_accum_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_accum_ctrl.sv
// Beat sequencer and saturating accumulator for the 8-lane pos/neg adder tree.
// One signed result per job, returned over a valid/ready port.
module adder_tree_accum_ctrl #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_chunks,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_vec,
  input  logic [7:0]       in_sign,
  output logic [127:0]     tree_in_vec,
  output logic [7:0]       tree_sign_vec,
  input  logic [15:0]      tree_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_sat,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic             stg_v_q, stg_v_d;
  logic             cfg_err_q, cfg_err_d;
  logic [127:0]     tvec_q, tvec_d;
  logic [7:0]       tsgn_q, tsgn_d;

  logic             hs;
  logic [ACC_W:0]   sum;
  logic             ovf;

  assign hs  = in_valid && (state_q == S_RUN);
  assign sum = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-16){tree_out[15]}}, tree_out};
  // Sign bits disagree only when the true sum left the ACC_W range.
  assign ovf = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    stg_v_d   = 1'b0;
    cfg_err_d = 1'b0;
    tvec_d    = '0;
    tsgn_d    = '0;

    if (stg_v_q) begin
      if (ovf) begin
        acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_chunks != '0) begin
            state_d = S_RUN;
            acc_d   = '0;
            sat_d   = 1'b0;
            rem_d   = cfg_chunks;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (hs) begin
          tvec_d  = in_vec;
          tsgn_d  = in_sign;
          stg_v_d = 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      // Stay until the staged last beat has been folded in.
      S_DRAIN: begin
        if (!stg_v_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      acc_d     = '0;
      rem_d     = '0;
      stg_v_d   = 1'b0;
      cfg_err_d = 1'b0;
      tvec_d    = '0;
      tsgn_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      stg_v_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      tvec_q    <= '0;
      tsgn_q    <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      stg_v_q   <= stg_v_d;
      cfg_err_q <= cfg_err_d;
      tvec_q    <= tvec_d;
      tsgn_q    <= tsgn_d;
    end
  end

  assign in_ready      = (state_q == S_RUN);
  assign res_valid     = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign res_data      = acc_q;
  assign res_sat       = sat_q;
  assign cfg_err       = cfg_err_q;
  assign tree_in_vec   = tvec_q;
  assign tree_sign_vec = tsgn_q;

endmodule

// File: tb/tb_adder_tree_accum_ctrl.sv
// Bench for adder_tree_accum_ctrl: two instances (ACC_W 24 and 16)
// share stimulus; results are checked against an integer job model.
module tb_adder_tree_accum_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [7:0]   cfg_chunks;
  logic         abort;
  logic         in_valid;
  logic [127:0] in_vec;
  logic [7:0]   in_sign;
  logic         res_ready;

  logic         rdy_a, rv_a, sat_a, busy_a, err_a;
  logic [127:0] tv_a;
  logic [7:0]   ts_a;
  logic [15:0]  to_a;
  logic [23:0]  rd_a;

  logic         rdy_b, rv_b, sat_b, busy_b, err_b;
  logic [127:0] tv_b;
  logic [7:0]   ts_b;
  logic [15:0]  to_b;
  logic [15:0]  rd_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] lanes [16][8];
  logic [7:0]  signs [16];

  always #5 clk = ~clk;

  function automatic logic [15:0] tree_fn(logic [127:0] v, logic [7:0] s);
    logic [15:0] acc;
    acc = '0;
    for (int j = 0; j < 8; j++) begin
      if (s[j]) acc = acc - v[16*j +: 16];
      else      acc = acc + v[16*j +: 16];
    end
    return acc;
  endfunction

  assign to_a = tree_fn(tv_a, ts_a);
  assign to_b = tree_fn(tv_b, ts_b);

  adder_tree_accum_ctrl #(.ACC_W(24), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_chunks(cfg_chunks),
    .abort(abort), .in_valid(in_valid), .in_ready(rdy_a),
    .in_vec(in_vec), .in_sign(in_sign), .tree_in_vec(tv_a),
    .tree_sign_vec(ts_a), .tree_out(to_a), .res_valid(rv_a),
    .res_ready(res_ready), .res_data(rd_a), .res_sat(sat_a),
    .busy(busy_a), .cfg_err(err_a)
  );

  adder_tree_accum_ctrl #(.ACC_W(16), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_chunks(cfg_chunks),
    .abort(abort), .in_valid(in_valid), .in_ready(rdy_b),
    .in_vec(in_vec), .in_sign(in_sign), .tree_in_vec(tv_b),
    .tree_sign_vec(ts_b), .tree_out(to_b), .res_valid(rv_b),
    .res_ready(res_ready), .res_data(rd_b), .res_sat(sat_b),
    .busy(busy_b), .cfg_err(err_b)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Job model: signed lane sums wrapped to 16 bits, then a clamped running sum.
  function automatic longint model(int n, int w, output bit sat);
    longint acc, lo, hi, t;
    acc = 0;
    sat = 1'b0;
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -(longint'(1) << (w - 1));
    for (int i = 0; i < n; i++) begin
      t = 0;
      for (int j = 0; j < 8; j++) begin
        if (signs[i][j]) t = t - longint'(lanes[i][j]);
        else             t = t + longint'(lanes[i][j]);
      end
      t = t & 64'hFFFF;
      if (t >= 32768) t = t - 65536;
      acc = acc + t;
      if (acc > hi) begin acc = hi; sat = 1'b1; end
      if (acc < lo) begin acc = lo; sat = 1'b1; end
    end
    return acc;
  endfunction

  function automatic logic [127:0] pack(int i);
    logic [127:0] v;
    for (int j = 0; j < 8; j++) v[16*j +: 16] = lanes[i][j];
    return v;
  endfunction

  task automatic fill_const(int i, logic [15:0] val, logic [7:0] s);
    for (int j = 0; j < 8; j++) lanes[i][j] = val;
    signs[i] = s;
  endtask

  task automatic fill_rand(int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) lanes[i][j] = 16'($urandom);
      signs[i] = 8'($urandom);
    end
  endtask

  task automatic do_job(int n, int gap, int stall);
    int i, cyc;
    bit hs;
    longint ea, eb;
    bit sa, sb;
    @(negedge clk);
    start = 1'b1;
    cfg_chunks = 8'(n);
    @(negedge clk);
    start = 1'b0;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 2000) begin
      in_valid = (gap == 0) || ($urandom_range(99) >= gap);
      in_vec   = pack(i);
      in_sign  = signs[i];
      hs = in_valid && rdy_a;
      @(negedge clk);
      if (hs) begin
        chk("tree_vec", tv_a === pack(i), 1);
        chk("tree_sign", ts_a, signs[i]);
        i++;
      end else begin
        chk("tree_zero", tv_a === '0, 1);
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("beats_taken", i, n);
    chk("rv_k0", rv_a, 0);
    @(negedge clk);
    chk("rv_k1", rv_a, 0);
    chk("ready_drain", rdy_a, 0);
    @(negedge clk);
    chk("rv_k2", rv_a, 1);
    chk("rv16_k2", rv_b, 1);
    ea = model(n, 24, sa);
    eb = model(n, 16, sb);
    for (int s = 0; s <= stall; s++) begin
      chk("res24", $signed(rd_a), ea);
      chk("res16", $signed(rd_b), eb);
      chk("sat24", sat_a, sa);
      chk("sat16", sat_b, sb);
      if (s < stall) begin
        @(negedge clk);
        chk("rv_hold", rv_a, 1);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("rv_drop", rv_a, 0);
    chk("busy_idle", busy_a, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_chunks = '0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_vec = '0;
    in_sign = '0;
    res_ready = 1'b0;
    #12;
    chk("rst_busy", busy_a, 0);
    chk("rst_ready", rdy_a, 0);
    chk("rst_rv", rv_a, 0);
    chk("rst_data", rd_a, 0);
    chk("rst_sat", sat_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_tree", tv_a === '0 && ts_a === '0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 8; j++) lanes[i][j] = 16'(j + 1);
      signs[i] = 8'h00;
    end
    do_job(4, 0, 0);
    chk("dir_144", $signed(rd_a), 144);

    fill_const(0, 16'd100, 8'hFF);
    fill_const(1, 16'd10, 8'h0F);
    do_job(2, 0, 0);
    chk("dir_m800", $signed(rd_a), -800);

    for (int i = 0; i < 3; i++) fill_const(i, 16'h1000, 8'h00);
    do_job(3, 0, 0);
    chk("sat16_val", $signed(rd_b), -32768);
    chk("sat16_flag", sat_b, 1);
    chk("sat24_val", $signed(rd_a), -98304);

    fill_rand(6);
    do_job(6, 0, 0);
    do_job(6, 40, 5);
    for (int r = 0; r < 3; r++) begin
      fill_rand(1 + $urandom_range(9));
      do_job(1 + $urandom_range(9), 30, $urandom_range(3));
    end

    @(negedge clk);
    start = 1'b1;
    cfg_chunks = '0;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", err_a, 1);
    chk("cfg_err_busy", busy_a, 0);
    chk("cfg_err_ready", rdy_a, 0);
    @(negedge clk);
    chk("cfg_err_once", err_a, 0);
    chk("cfg_err_busy2", busy_a, 0);

    fill_rand(5);
    start = 1'b1;
    cfg_chunks = 8'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_vec = pack(i);
      in_sign = signs[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_ready", rdy_a, 0);
    chk("abort_acc", rd_a, 0);
    chk("abort_tree", tv_a === '0 && ts_a === '0, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_rv", rv_a, 0);
      chk("abort_no_err", err_a, 0);
    end
    fill_rand(1);
    do_job(1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
